// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order fetch requests under a credit limit,
// buffers returned words with their PCs, and flushes cleanly on a redirect.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,

    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,

    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      redirect_aligned;

    logic req_fire;
    logic resp_take;
    logic resp_drop;
    logic enq;
    logic deq;

    // Every queued entry plus every outstanding request holds one slot, so the
    // queue can never be asked to absorb more than DEPTH words.
    assign credit_used      = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid   = rst_n && !redirect_valid && (credit_used < DEPTH_EXT);
    assign imem_req_addr    = fetch_pc;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_take = imem_resp_valid && (inflight != '0);
    assign resp_drop = resp_take && (discard != '0);
    assign enq       = resp_take && (discard == '0) && !redirect_valid;

    assign out_valid = (count != '0);
    assign deq       = out_valid && !stall && !redirect_valid;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];

    always_comb begin
        inflight_next = inflight;
        if (req_fire && !resp_take) begin
            inflight_next = inflight + 1'b1;
        end else if (!req_fire && resp_take) begin
            inflight_next = inflight - 1'b1;
        end
    end

    // On a redirect everything still in flight belongs to the old path, so the
    // surviving inflight count becomes the number of responses to throw away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect_valid) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight_next;
            discard  <= inflight_next;
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
        end else begin
            inflight <= inflight_next;
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp_drop) begin
                discard <= discard - 1'b1;
            end
            if (enq) begin
                wr_ptr  <= wr_ptr + 1'b1;
                resp_pc <= resp_pc + 32'd4;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (!enq && deq) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && enq) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable memory responder plus
// hand-computed checks of fetch order, credit limit, redirect flush and reset.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned lat   = 1;
    int          acc_cnt = 0;
    int          acc_base;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t pend_q[$];

    fetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns {8'h13, addr[23:0]} exactly lat cycles after acceptance.
    always @(negedge clk) begin
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = {8'h13, pend_q[0].addr[23:0]};
            void'(pend_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            acc_cnt = acc_cnt + 1;
        end
    end

    task automatic applyStimulus(input logic rst_v, input logic ready_v, input logic stall_v,
                                 input logic redir_v, input logic [31:0] redir_pc_v);
        @(posedge clk);
        #2;
        rst_n          = rst_v;
        imem_req_ready = ready_v;
        stall          = stall_v;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc_v;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic holdReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_req_valid", imem_req_valid, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_out_valid", out_valid, 32'h0);
        checkOutput("rst_req_valid_ready", imem_req_valid, 32'h0);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);

        // Streaming with 1-cycle memory
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s1_req_valid", imem_req_valid, 32'h1);
        checkOutput("s1_addr0", imem_req_addr, 32'h0);
        checkOutput("s1_out_valid_n0", out_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s1_addr1", imem_req_addr, 32'h4);
        checkOutput("s1_out_valid_n1", out_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s1_out_valid_n2", out_valid, 32'h1);
        checkOutput("s1_out_pc0", out_pc, 32'h0);
        checkOutput("s1_out_instr0", out_instr, 32'h1300_0000);
        checkOutput("s1_addr2", imem_req_addr, 32'h8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s1_out_pc1", out_pc, 32'h4);
        checkOutput("s1_addr3", imem_req_addr, 32'hC);
        holdReset(3);

        // Stall held for 10 cycles: credit saturates at four fetches
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        acc_base = acc_cnt;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        checkOutput("s2_accepts", 32'(acc_cnt - acc_base), 32'd4);
        checkOutput("s2_req_valid_sat", imem_req_valid, 32'h0);
        checkOutput("s2_out_valid", out_valid, 32'h1);
        checkOutput("s2_out_pc_held", out_pc, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s2_req_valid_full", imem_req_valid, 32'h0);
        checkOutput("s2_drain_pc0", out_pc, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s2_drain_pc1", out_pc, 32'h4);
        checkOutput("s2_next_addr", imem_req_addr, 32'h10);
        checkOutput("s2_req_valid_resume", imem_req_valid, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s2_drain_pc2", out_pc, 32'h8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s2_drain_pc3", out_pc, 32'hC);
        checkOutput("s2_drain_instr3", out_instr, 32'h1300_000C);
        holdReset(3);

        // 3-cycle memory, redirect to 0x100 with two requests inflight
        lat = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s3_addr0", imem_req_addr, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s3_addr1", imem_req_addr, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        checkOutput("s3_req_valid_redir", imem_req_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s3_req_valid_post", imem_req_valid, 32'h1);
        checkOutput("s3_addr_redir", imem_req_addr, 32'h100);
        checkOutput("s3_out_valid_c3", out_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s3_out_valid_c4", out_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s3_out_valid_c5", out_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s3_out_valid_c6", out_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s3_out_valid_c7", out_valid, 32'h1);
        checkOutput("s3_out_pc", out_pc, 32'h100);
        checkOutput("s3_out_instr", out_instr, 32'h1300_0100);
        holdReset(6);

        // Misaligned redirect target, then redirect colliding with response and dequeue
        lat = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h103);
        checkOutput("s4_req_valid_redir", imem_req_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s4_req_valid", imem_req_valid, 32'h1);
        checkOutput("s4_addr_aligned", imem_req_addr, 32'h100);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s4_addr_next", imem_req_addr, 32'h104);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        checkOutput("s5_out_valid_pre", out_valid, 32'h1);
        checkOutput("s5_out_pc_pre", out_pc, 32'h100);
        checkOutput("s5_req_valid_redir", imem_req_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s5_queue_empty", out_valid, 32'h0);
        checkOutput("s5_addr_new", imem_req_addr, 32'h200);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s5_out_valid_d5", out_valid, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("s5_out_valid_d6", out_valid, 32'h1);
        checkOutput("s5_out_pc_new", out_pc, 32'h200);
        checkOutput("s5_out_instr_new", out_instr, 32'h1300_0200);

        // Reset with three entries queued and one request inflight
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        lat = 2;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("s6_out_valid_pre", out_valid, 32'h1);
        checkOutput("s6_req_valid_rst", imem_req_valid, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s6_out_valid_post", out_valid, 32'h0);
        checkOutput("s6_addr_post", imem_req_addr, 32'h0);
        checkOutput("s6_req_valid_post", imem_req_valid, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s6_late_resp_ignored", out_valid, 32'h0);
        checkOutput("s6_addr_hold", imem_req_addr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s6_still_empty", out_valid, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning prefetch queue entries (power of 2, at least 2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state updates on its posedge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  instruction memory accepts the request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_resp_valid  input  1  response data valid; responses return in order, one per accepted request, at least 1 cycle after acceptance.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  taken branch or jump; pipeline flush.
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 stall  input  1  hazard stall from decode; holds the queue head.
REQ-013 out_valid  output  1  queue head holds a valid instruction.
REQ-014 out_pc  output  32  PC of the queue head.
REQ-015 out_instr  output  32  instruction word of the queue head.

Function
REQ-016 The block SHALL hold a DEPTH-entry circular FIFO of {pc, instr} with read/write pointers and a count of width log2(DEPTH)+1.
REQ-017 The block SHALL track an inflight counter (requests accepted but not yet responded to) and a discard counter, each of width log2(DEPTH)+1.
REQ-018 imem_req_valid SHALL be 1 iff rst_n=1, redirect_valid=0, and count+inflight<DEPTH (credit rule); it SHALL be 0 in the reset cycle.
REQ-019 imem_req_addr SHALL equal fetch_pc; on a request handshake (valid&&ready), fetch_pc SHALL advance by 4 and inflight SHALL increment.
REQ-020 The block SHALL keep a resp_pc register; each non-discarded response SHALL be enqueued as {resp_pc, imem_resp_data}, after which resp_pc advances by 4.
REQ-021 On a response while discard>0, the block SHALL drop the data and decrement discard; inflight SHALL still decrement.
REQ-022 A response arriving while inflight=0 SHALL be ignored with no state change.
REQ-023 out_valid SHALL equal (count!=0) from registered state, and out_pc/out_instr SHALL show the head entry (don't-care when out_valid=0).
REQ-024 A dequeue SHALL occur when out_valid=1 and stall=0 and redirect_valid=0.
REQ-025 A simultaneous enqueue and dequeue SHALL leave count unchanged, and pointers SHALL wrap modulo DEPTH.
REQ-026 The credit rule SHALL guarantee an enqueue never occurs when full, so no overflow path is required.
REQ-027 Latency SHALL be: request accepted in cycle N, response in cycle N+1, out_valid=1 in cycle N+2; there is no bypass.
REQ-028 On redirect_valid=1 (priority over all other events), the next state SHALL be: count=0, pointers reset, fetch_pc=resp_pc={redirect_pc[31:2],2'b00}, discard=inflight minus (1 if a response arrives this cycle), inflight=inflight minus (1 if a response arrives this cycle).
REQ-029 During a redirect cycle, no request SHALL be issued, no enqueue SHALL occur, and no dequeue SHALL occur.
REQ-030 A redirect while discard>0 SHALL set discard to the remaining inflight count computed per REQ-028.
REQ-031 stall=1 SHALL hold the head entry stable while fetching continues until the credit rule saturates.

Reset
REQ-032 When rst_n=0 at posedge clk, the block SHALL set count=0, pointers=0, inflight=0, discard=0, fetch_pc=resp_pc=RESET_PC, out_valid=0 and imem_req_valid=0.
REQ-033 Reset mid-operation SHALL abandon outstanding requests; any responses arriving after reset are ignored per REQ-022.

Verification
REQ-034 Bench SHALL cover: reset release, ready=1, 1-cycle memory -> requests at addresses 0x0,0x4,0x8,...; first out_valid 2 cycles after the first accept, with out_pc=0x0.
REQ-035 Bench SHALL cover: stall=1 held for 10 cycles -> exactly DEPTH=4 entries fetched, imem_req_valid=0 thereafter, out_pc held at 0x0.
REQ-036 Bench SHALL cover: 3-cycle memory latency with redirect to 0x100 while 2 requests are inflight -> both stale responses dropped, next out_pc=0x100 and next request addr=0x100.
REQ-037 Bench SHALL cover: redirect_pc=0x103 -> request addr 0x100.
REQ-038 Bench SHALL cover: redirect in the same cycle as a response and a dequeue -> response dropped, no dequeue, queue empty next cycle.
REQ-039 Bench SHALL cover: rst_n=0 asserted with 3 entries queued and 1 request inflight -> out_valid=0 and imem_req_addr=RESET_PC the next cycle; a late response is ignored.
